data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//   Responder for the core's data-write interface (mem_addr/mem_data/mem_we).
//   Decodes each write into a word RAM region or an MMIO output channel.
//   MMIO words are buffered in a FIFO and drained to an external consumer over a
//   valid/ready handshake. The core cannot stall, so lost writes are flagged with
//   sticky error bits. A registered debug read port exposes RAM to the testbench.
// PARAMETERS
//   RAM_AW      8             RAM address width; depth = 2**RAM_AW 32-bit words
//   MMIO_BASE   32'h0000_1000 word address of the MMIO output data register
//   FIFO_AW     2             FIFO address width; depth = 2**FIFO_AW entries
// PORTS
//   clk        in   1        clock; all state updates on posedge
//   rst_n      in   1        asynchronous, active-low reset
//   mem_addr   in   32       word address from core (ALU result)
//   mem_data   in   32       write data from core (rs2 value)
//   mem_we     in   1        write strobe; one write per cycle while high
//   out_data   out  32       FIFO head word
//   out_valid  out  1        FIFO non-empty
//   out_ready  in   1        consumer accepts head when out_valid & out_ready
//   fifo_cnt   out  FIFO_AW+1 current FIFO occupancy, 0..2**FIFO_AW
//   ovf        out  1        sticky: MMIO write dropped because FIFO was full
//   bad_addr   out  1        sticky: write to an unmapped address
//   wr_cnt     out  32       count of accepted RAM writes, wraps 2^32-1 -> 0
//   dbg_addr   in   RAM_AW   debug read address
//   dbg_data   out  32       RAM[dbg_addr], registered
// BEHAVIOUR
//   Reset (async on rst_n low): out_valid=0, fifo_cnt=0, rd/wr ptrs=0, ovf=0,
//     bad_addr=0, wr_cnt=0, dbg_data=0. RAM contents are not reset.
//   Decode while mem_we=1, evaluated on mem_addr as a whole 32-bit word address:
//     addr < 2**RAM_AW : RAM[addr] <= mem_data on this edge; wr_cnt += 1.
//     addr == MMIO_BASE: push mem_data into the FIFO.
//     addr == MMIO_BASE+1: clear ovf and bad_addr; mem_data is ignored.
//     Any other address: write dropped; bad_addr <= 1.
//   mem_we=0: no state change from the write side.
//   Debug read: dbg_data <= RAM[dbg_addr] every cycle, 1-cycle latency.
//     A write and a read to the same address on the same edge return the OLD word.
//   FIFO timing:
//     out_data is combinational from the head entry.
//     out_valid = (fifo_cnt != 0).
//     A pop occurs when out_valid & out_ready. out_ready while empty is a no-op.
//   FIFO boundary cases:
//     Push into an empty FIFO: out_valid=1 and out_data=word in the next cycle.
//     Push and pop together, not full: both execute; fifo_cnt unchanged.
//     Push and pop together, full: both execute; the word is accepted; ovf unchanged.
//     Push into a full FIFO with no pop: word dropped, ovf <= 1, FIFO unchanged.
//     Pointers wrap modulo 2**FIFO_AW.
//   Clear vs error on the same edge: a clear and a new error event cannot share an
//     edge, since only one write occurs per cycle. Sticky bits hold until a clear
//     write or reset.
//   out_data/out_valid must stay stable while out_valid & !out_ready.
//   Reset asserted mid-drain: FIFO is emptied immediately and out_valid drops
//     asynchronously. Words in flight are lost.
// TESTING
//   1. Reset, write RAM[5]=32'hDEAD_BEEF, set dbg_addr=5 -> dbg_data=DEADBEEF
//      one cycle later; wr_cnt=1.
//   2. out_ready=0, 5 writes to MMIO_BASE (values 1..5) -> fifo_cnt=4, ovf=1;
//      raise out_ready -> consumer sees 1,2,3,4 in order, then out_valid=0.
//   3. FIFO full, push 9 with out_ready=1 on the same edge -> 9 accepted, fifo_cnt
//      stays 4, ovf stays 0.
//   4. Write to addr 32'h0000_0800 -> bad_addr=1, RAM and FIFO unchanged;
//      write MMIO_BASE+1 -> bad_addr=0, ovf=0.
//   5. Push 3 words, pull rst_n low mid-drain -> out_valid=0, fifo_cnt=0 with no
//      clock edge; RAM word written earlier is still readable.
//   6. Random mem_we/mem_addr/out_ready stream vs scoreboard model for 10k cycles
//      -> FIFO order, drop behaviour and wr_cnt all match.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-write responder: decodes core writes into a word RAM or an MMIO FIFO
// drained over valid/ready, with sticky error flags and a registered debug read.
module data_mem_responder #(
  parameter int unsigned RAM_AW    = 8,
  parameter logic [31:0] MMIO_BASE = 32'h0000_1000,
  parameter int unsigned FIFO_AW   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_data,
  input  logic               mem_we,
  output logic [31:0]        out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FIFO_AW:0]   fifo_cnt,
  output logic               ovf,
  output logic               bad_addr,
  output logic [31:0]        wr_cnt,
  input  logic [RAM_AW-1:0]  dbg_addr,
  output logic [31:0]        dbg_data
);

  localparam int unsigned FIFO_DEPTH = 2**FIFO_AW;

  logic [31:0]        ram      [2**RAM_AW];
  logic [31:0]        fifo_mem [FIFO_DEPTH];

  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               bad_q, bad_d;
  logic [31:0]        wr_cnt_q, wr_cnt_d;
  logic [31:0]        dbg_data_q, dbg_data_d;

  logic is_ram, is_mmio, is_clr, full, pop, push, ram_we;

  always_comb begin
    is_ram  = (mem_addr >> RAM_AW) == '0;
    is_mmio = mem_addr == MMIO_BASE;
    is_clr  = mem_addr == (MMIO_BASE + 32'd1);
    full    = cnt_q == (FIFO_AW+1)'(FIFO_DEPTH);
    pop     = (cnt_q != '0) && out_ready;
    ram_we  = mem_we && is_ram;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    push    = mem_we && !is_ram && is_mmio && (!full || pop);

    rd_ptr_d   = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    cnt_d      = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (FIFO_AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (FIFO_AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase

    ovf_d      = ovf_q;
    bad_d      = bad_q;
    wr_cnt_d   = ram_we ? wr_cnt_q + 32'd1 : wr_cnt_q;
    if (mem_we && !is_ram) begin
      if (is_mmio) begin
        if (full && !pop) ovf_d = 1'b1;
      end else if (is_clr) begin
        ovf_d = 1'b0;
        bad_d = 1'b0;
      end else begin
        bad_d = 1'b1;
      end
    end

    dbg_data_d = ram[dbg_addr];
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[mem_addr[RAM_AW-1:0]] <= mem_data;
    if (push)   fifo_mem[wr_ptr_q] <= mem_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      bad_q      <= 1'b0;
      wr_cnt_q   <= '0;
      dbg_data_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      bad_q      <= bad_d;
      wr_cnt_q   <= wr_cnt_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  assign out_data  = fifo_mem[rd_ptr_q];
  assign out_valid = cnt_q != '0;
  assign fifo_cnt  = cnt_q;
  assign ovf       = ovf_q;
  assign bad_addr  = bad_q;
  assign wr_cnt    = wr_cnt_q;
  assign dbg_data  = dbg_data_q;

endmodule
